// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Purpose : default 640x480@60 raster timing constants and a helper that
//           derives the total period (active + porches + sync) of one axis.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package video_timing_pkg;

    // Horizontal timing in pixels.
    localparam int VTG_H_ACTIVE = 640;
    localparam int VTG_H_FP     = 16;
    localparam int VTG_H_SYNC   = 96;
    localparam int VTG_H_BP     = 48;

    // Vertical timing in lines.
    localparam int VTG_V_ACTIVE = 480;
    localparam int VTG_V_FP     = 10;
    localparam int VTG_V_SYNC   = 2;
    localparam int VTG_V_BP     = 33;

    // Counter and position width.
    localparam int VTG_CW       = 10;

    // Full period of one axis.
    function automatic int vtg_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_axis_cnt.sv
// -----------------------------------------------------------------------------
// vtg_axis_cnt
// Purpose : one raster axis. A wrap counter running 0..TOTAL-1, plus the
//           combinational decode of its current value into active-window and
//           sync-level flags. Used once for pixels and once for lines.
// Ports   : clk, rst_n  - clock, asynchronous active-low reset
//           clr         - force the counter to 0 (higher priority than adv)
//           adv         - advance the counter by one, wrapping after TOTAL-1
//           cnt         - current counter value
//           last        - cnt is at TOTAL-1 (next advance wraps)
//           active      - cnt is inside the active window
//           sync        - sync level for cnt (POL inside the sync window)
// -----------------------------------------------------------------------------
module vtg_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = VTG_H_ACTIVE,
    parameter int FP     = VTG_H_FP,
    parameter int SYNC   = VTG_H_SYNC,
    parameter int BP     = VTG_H_BP,
    parameter bit POL    = 1'b0,
    parameter int CW     = VTG_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          last,
    output logic          active,
    output logic          sync
);

    localparam int TOTAL = vtg_total(ACTIVE, FP, SYNC, BP);

    // Window bounds carry one extra bit: a bound may equal 2^CW when the
    // trailing porches are zero, and must not truncate to 0.
    localparam logic [CW-1:0] LAST_C   = CW'(TOTAL - 1);
    localparam logic [CW:0]   ACT_END  = (CW+1)'(ACTIVE);
    localparam logic [CW:0]   SYNC_BEG = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0]   SYNC_END = (CW+1)'(ACTIVE + FP + SYNC);

    if (SYNC < 1) begin : g_bad_sync
        $error("vtg_axis_cnt: sync width must be non-zero");
    end
    if (longint'(TOTAL) > (longint'(1) << CW)) begin : g_bad_width
        $error("vtg_axis_cnt: TOTAL-1 does not fit in CW bits");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   cnt_x;
    logic          in_sync;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_x   = {1'b0, cnt_q};
    assign last    = (cnt_q == LAST_C);
    assign active  = (cnt_x < ACT_END);
    assign in_sync = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);
    assign sync    = in_sync ? POL : ~POL;
    assign cnt     = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Purpose : raster timing generator. Internal h/v counters advance on each
//           step (pix_en & run); the outputs register the decode of the
//           pre-step position, so they describe the pixel being emitted and
//           lag the counters by one step.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           pix_en           - single-cycle pixel step strobe
//           run              - timing enable; low holds the raster at (0,0)
//           hsync, vsync, de - sync levels and active-video flag
//           hcount, vcount   - position of the emitted pixel
//           line_start       - one-clk pulse: emitted pixel has h=0
//           frame_start      - one-clk pulse: emitted pixel is (0,0)
//           frame_cnt        - (VTG_FRAME_CNT_EN only) 8-bit count of frames
//                              completed, bumped when the last pixel of a
//                              frame is emitted
// Build option: define VTG_FRAME_CNT_EN to add the frame_cnt output.
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VTG_H_ACTIVE,
    parameter int H_FP     = VTG_H_FP,
    parameter int H_SYNC   = VTG_H_SYNC,
    parameter int H_BP     = VTG_H_BP,
    parameter int V_ACTIVE = VTG_V_ACTIVE,
    parameter int V_FP     = VTG_V_FP,
    parameter int V_SYNC   = VTG_V_SYNC,
    parameter int V_BP     = VTG_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = VTG_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    logic          step;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last, h_act, h_sync;
    logic          v_last, v_act, v_sync;

    assign step = pix_en & run;

    vtg_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~run),
        .adv    (step),
        .cnt    (h_cnt),
        .last   (h_last),
        .active (h_act),
        .sync   (h_sync)
    );

    // Lines advance only on the step that wraps the pixel counter, so the
    // vertical decode is constant across a line and vsync can only change
    // on the step that emits h=0.
    vtg_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~run),
        .adv    (step & h_last),
        .cnt    (v_cnt),
        .last   (v_last),
        .active (v_act),
        .sync   (v_sync)
    );

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (!run) begin
            // Blank the output but keep the last reported position.
            de_d    = 1'b0;
            hsync_d = ~HS_POL;
            vsync_d = ~VS_POL;
        end else if (pix_en) begin
            hcount_d      = h_cnt;
            vcount_d      = v_cnt;
            de_d          = h_act & v_act;
            hsync_d       = h_sync;
            vsync_d       = v_sync;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VTG_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Counts the step emitting the last pixel of a frame; run=0 leaves it.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (step && h_last && v_last) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0 each, giving the asserted sync level (0 = active-low).
REQ-006 SHALL have parameter CW, default 10, counter and position width.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port pix_en, input, 1, single-cycle pixel step strobe.
REQ-010 SHALL have port run, input, 1, timing enable (low = hold at frame origin).
REQ-011 SHALL have ports hsync, vsync, de, output, 1 each: sync levels and active-video flag.
REQ-012 SHALL have ports hcount, vcount, output, CW each: position of the emitted pixel.
REQ-013 SHALL have ports line_start, frame_start, output, 1 each: pulses marking the emitted pixel at h=0 and at (0,0).

Function
REQ-014 SHALL keep internal counters h and v; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the vertical parameters.
REQ-015 SHALL define a step as a clk edge with pix_en=1 and run=1; cycles without a step SHALL hold all counters and outputs, except the pulses, which clear.
REQ-016 On a step, h SHALL advance by 1; at h=H_TOTAL-1, h SHALL wrap to 0 and v SHALL advance by 1.
REQ-017 At the same step, if v=V_TOTAL-1, v SHALL wrap to 0.
REQ-018 On a step, all outputs SHALL register the decode of the pre-step (h,v), giving a one-step latency from counter to output.
REQ-019 hcount and vcount SHALL equal the pre-step h and v.
REQ-020 de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-021 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-022 vsync SHALL equal VS_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise; vsync is line-granular and changes only at steps where h=0.
REQ-023 line_start SHALL be 1 for exactly the clk after a step with h=0; frame_start SHALL be 1 for exactly the clk after a step with h=0 and v=0.
REQ-024 While run=0, each clk SHALL clear h and v to 0, drive de=0, drive hsync and vsync to their inactive levels, clear line_start and frame_start, and leave hcount and vcount unchanged; pix_en is ignored.
REQ-025 The first step after run rises SHALL emit pixel (0,0) with frame_start=1.
REQ-026 Elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if any sync width is 0.

Reset
REQ-027 rst_n low SHALL asynchronously set h=v=0, hcount=vcount=0, de=0, hsync=~HS_POL, vsync=~VS_POL, and line_start=frame_start=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the first step after release SHALL emit (0,0).

Configuration
REQ-029 With VTG_FRAME_CNT_EN defined, SHALL add output frame_cnt, 8 bits, reset 0, incremented on every step that emits (H_TOTAL-1, V_TOTAL-1) and wrapping 255->0; run=0 SHALL NOT clear it.
REQ-030 Without VTG_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-031 Package video_timing_pkg SHALL hold the 640x480@60 default timing constants and a derived-total helper function.
REQ-032 A sub-module vtg_axis_cnt (wrap counter plus sync/active window decode, instanced once per axis) SHALL implement the h and v axes.

Verification
REQ-033 Defaults, reset release, run=1, pix_en every 2nd clk -> first step gives hcount=0, vcount=0, de=1, frame_start=1; hsync=0 exactly for hcount 656..751.
REQ-034 Defaults, full frame -> de=1 count=307200; vsync=0 for vcount 490..491; vcount wraps 524->0 with frame_start on (0,0); 420000 steps per frame.
REQ-035 pix_en held 0 for 50 clks mid-line -> outputs static; line_start and frame_start stay 0.
REQ-036 run dropped at (300,200), then raised -> de=0, syncs inactive while low; next step emits (0,0) with frame_start=1.
REQ-037 rst_n pulsed low mid-frame -> outputs go to reset values immediately, without waiting for a clk edge.
REQ-038 Parameters H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1, VTG_FRAME_CNT_EN defined -> H_TOTAL=8, hsync=1 at h=5..6, frame_cnt=3 after 3 frames.
